// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the 4x4 keypad key controller.
//   - keyState_e      : controller sequencing states
//   - KEYMAP          : [row][col] -> hex key code lookup
//   - onehot4_to_idx  : converts a one-hot 4-bit row/column select to a 2-bit index
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    ACCEPT,
    HELD,
    RESUME
  } keyState_e;

  // Physical keypad layout:
  //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // The input is expected to be one-hot; the highest set bit wins if not.
  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oneHot);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oneHot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_key_controller.sv
// keypad_key_controller
//   Sequencer sitting behind the 4x4 row scanner. Debounces the candidate key,
//   releases the scanner's row hold with a one-cycle key_valid pulse, decodes
//   the accepted key to hex, emits one new_key pulse per physical press and
//   keeps a two-digit history for the dual 7-segment display.
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous, active-low reset
//   key_pressed_i  in   scanner reports exactly one column low
//   row_idx_i      in   [3:0] one-hot active row
//   col_idx_i      in   [3:0] one-hot pressed column (0000 = none/ghost)
//   key_valid_o    out  one-cycle pulse telling the scanner to resume
//   new_key_o      out  one-cycle pulse, key accepted (code/digits valid now)
//   key_code_o     out  [3:0] hex code of last accepted key
//   digit_lo_o     out  [3:0] most recent key code
//   digit_hi_o     out  [3:0] previous key code
//   busy_o         out  high whenever the controller is not idle
module keypad_key_controller
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int RELEASE_CYCLES  = 60000,
  parameter int GUARD_CYCLES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_pressed_i,
  input  logic [3:0] row_idx_i,
  input  logic [3:0] col_idx_i,
  output logic       key_valid_o,
  output logic       new_key_o,
  output logic [3:0] key_code_o,
  output logic [3:0] digit_lo_o,
  output logic [3:0] digit_hi_o,
  output logic       busy_o
);

  // One counter serves debounce, release and guard timing, so it is sized
  // for the longest of the three intervals.
  localparam int LongDbRel = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
  localparam int LongCnt   = (LongDbRel > GUARD_CYCLES) ? LongDbRel : GUARD_CYCLES;
  localparam int CntW      = $clog2(LongCnt + 1);

  localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] RelLast   = CntW'(RELEASE_CYCLES - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);

  keyState_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      candRow_q;
  logic [3:0]      candCol_q;
  logic [3:0]      keyCode_q;
  logic [3:0]      digitLo_q;
  logic [3:0]      digitHi_q;

  logic       qualify;
  logic       match;
  logic [3:0] candCode;

  // A key is only believable when the scanner sees exactly one row and one
  // column; anything else (ghosting, multi-key) is treated as no key.
  always_comb begin
    qualify  = key_pressed_i & $onehot(row_idx_i) & $onehot(col_idx_i);
    match    = qualify && (row_idx_i == candRow_q) && (col_idx_i == candCol_q);
    candCode = KEYMAP[onehot4_to_idx(candRow_q)][onehot4_to_idx(candCol_q)];
  end

  // Main sequencer. The counter never wraps: every state that increments it
  // leaves (or clears it) on reaching its terminal count. Every path into
  // RESUME clears the counter so the first RESUME cycle is identifiable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      candRow_q <= '0;
      candCol_q <= '0;
      keyCode_q <= '0;
      digitLo_q <= '0;
      digitHi_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (qualify) begin
            candRow_q <= row_idx_i;
            candCol_q <= col_idx_i;
            cnt_q     <= '0;
            state_q   <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (match) begin
            if (cnt_q == DebLast) begin
              keyCode_q <= candCode;
              digitLo_q <= candCode;
              digitHi_q <= digitLo_q;
              cnt_q     <= '0;
              state_q   <= ACCEPT;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else begin
            // Aborted press still has to release the scanner's row hold.
            cnt_q   <= '0;
            state_q <= RESUME;
          end
        end
        ACCEPT: begin
          cnt_q   <= '0;
          state_q <= HELD;
        end
        HELD: begin
          // A re-press glitch restarts the release count; new_key is never
          // re-issued from here, which is what suppresses auto-repeat.
          if (key_pressed_i) begin
            cnt_q <= '0;
          end else if (cnt_q == RelLast) begin
            cnt_q   <= '0;
            state_q <= RESUME;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESUME: begin
          // Guard window covers the scanner advancing and its column
          // synchroniser settling; key_pressed is not looked at here.
          if (cnt_q == GuardLast) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Pulses and busy come purely from registered state, so they cannot glitch
  // on input activity. key_valid marks only the first RESUME cycle.
  always_comb begin
    new_key_o   = (state_q == ACCEPT);
    key_valid_o = (state_q == RESUME) && (cnt_q == '0);
    busy_o      = (state_q != IDLE);
    key_code_o  = keyCode_q;
    digit_lo_o  = digitLo_q;
    digit_hi_o  = digitHi_q;
  end

endmodule
